// File: rtl/ssr_pkg.sv
// Shared types and sizes for the speech-recognition frame scheduler.
// Optional feature: SSR_NN_WATCHDOG_EN enables the WAIT_NN watchdog.
package ssr_pkg;

    localparam int N_FEAT      = 26;
    localparam int FEAT_W      = 16;
    localparam int CLS_W       = 2;
    localparam int TIMEOUT_CYC = 4096;
    localparam int IDX_W       = $clog2(N_FEAT);
    localparam int WD_W        = $clog2(TIMEOUT_CYC);

    typedef logic signed [FEAT_W-1:0] feat_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        LAUNCH  = 3'd2,
        WAIT_NN = 3'd3,
        PUBLISH = 3'd4
    } sched_state_t;

endpackage

// File: rtl/nn_frame_sched_feat_frame_buf.sv
// Frame register buffer: one indexed write port plus the write index counter.
// The whole array is exposed so the network sees every feature in parallel.
module feat_frame_buf
    import ssr_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_wr_en,
    input  feat_t            i_wr_data,
    output logic [IDX_W-1:0] o_idx,
    output feat_t            o_frame [N_FEAT-1:0]
);

    logic [IDX_W-1:0] r_idx;
    feat_t            r_frame [N_FEAT-1:0];

    // Store accepted features bit-exact at the current index and advance it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx <= {IDX_W{1'b0}};
            for (int i = 0; i < N_FEAT; i++) begin
                r_frame[i] <= {FEAT_W{1'b0}};
            end
        end else if (i_clr) begin
            r_idx <= {IDX_W{1'b0}};
        end else if (i_wr_en) begin
            r_frame[r_idx] <= i_wr_data;
            r_idx          <= r_idx + {{(IDX_W-1){1'b0}}, 1'b1};
        end else begin
            r_idx <= r_idx;
        end
    end

    assign o_idx   = r_idx;
    assign o_frame = r_frame;

endmodule

// File: rtl/nn_frame_sched.sv
// Frame sequencer between the feature front-end and the neural network.
// Optional feature: SSR_NN_WATCHDOG_EN adds a timeout in WAIT_NN.
module nn_frame_sched
    import ssr_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             but,
    input  logic             feat_valid,
    input  feat_t            feat_data,
    input  logic             feat_last,
    output logic             feat_ready,
    output feat_t            input_vector [N_FEAT-1:0],
    output logic             nn_start,
    input  logic             nn_done,
    input  logic [CLS_W-1:0] nn_value,
    output logic [CLS_W-1:0] speech_rec,
    output logic             rec_valid,
    output logic             busy,
    output logic             err
);

    sched_state_t     r_state;
    sched_state_t     w_state_nxt;
    logic             r_but_d;
    logic             w_but_rise;
    logic             w_accept;
    logic             w_clr_idx;
    logic             w_err_nxt;
    logic [IDX_W-1:0] w_idx;
    logic             r_feat_ready;
    logic             r_nn_start;
    logic             r_rec_valid;
    logic             r_busy;
    logic             r_err;
    logic [CLS_W-1:0] r_speech_rec;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_FEAT - 1);

    assign w_but_rise = but & ~r_but_d;
    assign w_accept   = feat_valid & r_feat_ready;

    feat_frame_buf u_buf (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (w_clr_idx),
        .i_wr_en   (w_accept),
        .i_wr_data (feat_data),
        .o_idx     (w_idx),
        .o_frame   (input_vector)
    );

`ifdef SSR_NN_WATCHDOG_EN
    logic [WD_W-1:0] r_wd_cnt;

    // Watchdog counter: cleared while launching, counts every cycle in WAIT_NN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wd_cnt <= {WD_W{1'b0}};
        end else if (r_state == LAUNCH) begin
            r_wd_cnt <= {WD_W{1'b0}};
        end else if (r_state == WAIT_NN) begin
            r_wd_cnt <= r_wd_cnt + {{(WD_W-1){1'b0}}, 1'b1};
        end else begin
            r_wd_cnt <= r_wd_cnt;
        end
    end
`endif

    // Next-state logic; errors pulse err and abandon the frame without launching.
    always_comb begin
        w_state_nxt = r_state;
        w_err_nxt   = 1'b0;
        w_clr_idx   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_but_rise) begin
                    w_state_nxt = COLLECT;
                    w_clr_idx   = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            COLLECT: begin
                if (w_accept) begin
                    if (feat_last && (w_idx == LAST_IDX)) begin
                        w_state_nxt = LAUNCH;
                    end else if (feat_last || (w_idx == LAST_IDX)) begin
                        w_state_nxt = IDLE;
                        w_err_nxt   = 1'b1;
                    end else begin
                        w_state_nxt = COLLECT;
                    end
                end else begin
                    w_state_nxt = COLLECT;
                end
            end
            LAUNCH: begin
                w_state_nxt = WAIT_NN;
            end
            WAIT_NN: begin
                if (nn_done) begin
                    w_state_nxt = PUBLISH;
`ifdef SSR_NN_WATCHDOG_EN
                end else if (r_wd_cnt == WD_W'(TIMEOUT_CYC - 1)) begin
                    w_state_nxt = IDLE;
                    w_err_nxt   = 1'b1;
`endif
                end else begin
                    w_state_nxt = WAIT_NN;
                end
            end
            PUBLISH: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State register, button history and registered decode of the outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_but_d      <= 1'b0;
            r_feat_ready <= 1'b0;
            r_nn_start   <= 1'b0;
            r_rec_valid  <= 1'b0;
            r_busy       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_but_d      <= but;
            r_feat_ready <= (w_state_nxt == COLLECT);
            r_nn_start   <= (w_state_nxt == LAUNCH);
            r_rec_valid  <= (w_state_nxt == PUBLISH);
            r_busy       <= (w_state_nxt != IDLE);
            r_err        <= w_err_nxt;
        end
    end

    // Class result register; only a result taken in WAIT_NN may update it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_speech_rec <= {CLS_W{1'b0}};
        end else if ((r_state == WAIT_NN) && nn_done) begin
            r_speech_rec <= nn_value;
        end else begin
            r_speech_rec <= r_speech_rec;
        end
    end

    assign feat_ready = r_feat_ready;
    assign nn_start   = r_nn_start;
    assign rec_valid  = r_rec_valid;
    assign busy       = r_busy;
    assign err        = r_err;
    assign speech_rec = r_speech_rec;

endmodule

// File: tb/tb_nn_frame_sched.sv
// Self-checking bench for nn_frame_sched with a class-result scoreboard.
module tb_nn_frame_sched;
    import ssr_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic             but;
    logic             feat_valid;
    feat_t            feat_data;
    logic             feat_last;
    logic             feat_ready;
    feat_t            input_vector [N_FEAT-1:0];
    logic             nn_start;
    logic             nn_done;
    logic [CLS_W-1:0] nn_value;
    logic [CLS_W-1:0] speech_rec;
    logic             rec_valid;
    logic             busy;
    logic             err;

    int n_vec  = 0;
    int n_miss = 0;
    int start_cnt = 0;
    int err_cnt   = 0;
    int rec_cnt   = 0;
    feat_t            m_buf [N_FEAT];
    int               m_idx;
    logic [CLS_W-1:0] exp_q [$];

    nn_frame_sched dut (
        .clk          (clk),
        .rst          (rst),
        .but          (but),
        .feat_valid   (feat_valid),
        .feat_data    (feat_data),
        .feat_last    (feat_last),
        .feat_ready   (feat_ready),
        .input_vector (input_vector),
        .nn_start     (nn_start),
        .nn_done      (nn_done),
        .nn_value     (nn_value),
        .speech_rec   (speech_rec),
        .rec_valid    (rec_valid),
        .busy         (busy),
        .err          (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pulse counters and scoreboard pop on every published class.
    always @(negedge clk) begin
        if (nn_start === 1'b1) start_cnt++;
        if (err === 1'b1) err_cnt++;
        if (rec_valid === 1'b1) begin
            rec_cnt++;
            if (exp_q.size() == 0) chk("rec_unexpected", 32'd1, 32'd0);
            else chk("speech_rec_sb", 32'(speech_rec), 32'(exp_q.pop_front()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame();
        but = 1'b0;
        tick();
        but = 1'b1;
        tick();
        chk("busy_start", 32'(busy), 32'd1);
        chk("ready_start", 32'(feat_ready), 32'd1);
        m_idx = 0;
    endtask

    task automatic send(input int n, input int last_at, input bit gap, input int base);
        for (int k = 0; k < n; k++) begin
            feat_valid = 1'b1;
            feat_data  = feat_t'(base + k);
            feat_last  = (k == last_at);
            m_buf[m_idx] = feat_data;
            m_idx++;
            tick();
            feat_valid = 1'b0;
            feat_last  = 1'b0;
            if (gap && (k < n - 1)) begin
                feat_last = 1'b1;
                tick();
                feat_last = 1'b0;
            end
        end
    endtask

    task automatic check_frame(input string tag);
        for (int k = 0; k < N_FEAT; k++) begin
            chk(tag, 32'(input_vector[k]), 32'(m_buf[k]));
        end
    endtask

    task automatic finish_nn(input logic [CLS_W-1:0] v);
        chk("nn_start_hi", 32'(nn_start), 32'd1);
        tick();
        chk("nn_start_lo", 32'(nn_start), 32'd0);
        check_frame("frame");
        nn_done  = 1'b1;
        nn_value = v;
        exp_q.push_back(v);
        tick();
        nn_done = 1'b0;
        chk("rec_valid_hi", 32'(rec_valid), 32'd1);
        chk("speech_rec", 32'(speech_rec), 32'(v));
        tick();
        chk("rec_valid_lo", 32'(rec_valid), 32'd0);
        chk("busy_done", 32'(busy), 32'd0);
    endtask

    initial begin
        int s0;
        int e0;
        int r0;
        logic any_nz;
        rst = 1'b1; but = 1'b0; feat_valid = 1'b0; feat_last = 1'b0;
        feat_data = '0; nn_done = 1'b0; nn_value = '0;
        for (int k = 0; k < N_FEAT; k++) m_buf[k] = '0;
        repeat (2) tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(feat_ready), 32'd0);
        chk("rst_start", 32'(nn_start), 32'd0);
        chk("rst_rec_valid", 32'(rec_valid), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_speech", 32'(speech_rec), 32'd0);
        rst = 1'b0;
        tick();

        // 1: reset in the middle of a frame
        start_frame();
        but = 1'b0;
        send(10, -1, 1'b0, 100);
        chk("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_ready", 32'(feat_ready), 32'd0);
        any_nz = 1'b0;
        for (int k = 0; k < N_FEAT; k++) any_nz = any_nz | (|input_vector[k]);
        chk("arst_buf_zero", 32'(any_nz), 32'd0);
        for (int k = 0; k < N_FEAT; k++) m_buf[k] = '0;
        tick();
        rst = 1'b0;
        tick();

        // 2: nominal frame k-13, class 2
        start_frame();
        but = 1'b0;
        send(N_FEAT, N_FEAT - 1, 1'b0, -13);
        chk("buf0_const", 32'(input_vector[0]), 32'hFFFF_FFF3);
        chk("buf25_const", 32'(input_vector[25]), 32'h0000_000C);
        finish_nn(2'd2);
        chk("start_cnt_t2", 32'(start_cnt), 32'd1);

        // 3: early last -> error, partial buffer kept, nn_done in IDLE ignored
        s0 = start_cnt; e0 = err_cnt;
        start_frame();
        but = 1'b0;
        send(10, 9, 1'b0, 500);
        chk("early_err", 32'(err), 32'd1);
        chk("early_busy", 32'(busy), 32'd0);
        tick();
        chk("early_err_lo", 32'(err), 32'd0);
        nn_done = 1'b1; nn_value = 2'd1;
        tick();
        nn_done = 1'b0;
        repeat (3) tick();
        chk("early_no_start", 32'(start_cnt), 32'(s0));
        chk("early_err_cnt", 32'(err_cnt), 32'(e0 + 1));
        chk("early_speech_kept", 32'(speech_rec), 32'd2);
        chk("partial_9", 32'(input_vector[9]), 32'(m_buf[9]));
        chk("partial_10", 32'(input_vector[10]), 32'(m_buf[10]));

        // 3b: 26 samples with no last -> error
        s0 = start_cnt;
        start_frame();
        but = 1'b0;
        send(N_FEAT, -1, 1'b0, 2000);
        chk("nolast_err", 32'(err), 32'd1);
        chk("nolast_busy", 32'(busy), 32'd0);
        tick();
        chk("nolast_no_start", 32'(start_cnt), 32'(s0));

        // 4: button held across a frame, extra edge during WAIT_NN
        s0 = start_cnt; r0 = rec_cnt;
        start_frame();
        send(N_FEAT, N_FEAT - 1, 1'b0, 1000);
        tick();
        but = 1'b0;
        tick();
        but = 1'b1;
        tick();
        chk("held_wait_busy", 32'(busy), 32'd1);
        nn_done = 1'b1; nn_value = 2'd1;
        exp_q.push_back(2'd1);
        tick();
        nn_done = 1'b0;
        chk("held_rec_valid", 32'(rec_valid), 32'd1);
        repeat (60) tick();
        chk("held_idle", 32'(busy), 32'd0);
        chk("held_one_start", 32'(start_cnt), 32'(s0 + 1));
        chk("held_one_rec", 32'(rec_cnt), 32'(r0 + 1));
        but = 1'b0;
        tick();

        // 6: valid toggling, feat_last asserted on idle cycles
        s0 = start_cnt;
        start_frame();
        but = 1'b0;
        send(N_FEAT, N_FEAT - 1, 1'b1, -500);
        finish_nn(2'd3);
        chk("gap_one_start", 32'(start_cnt), 32'(s0 + 1));

        // 5: network never answers
        start_frame();
        but = 1'b0;
        send(N_FEAT, N_FEAT - 1, 1'b0, 7);
        chk("wd_start", 32'(nn_start), 32'd1);
        tick();
`ifdef SSR_NN_WATCHDOG_EN
        repeat (TIMEOUT_CYC - 1) tick();
        chk("wd_before_busy", 32'(busy), 32'd1);
        chk("wd_before_err", 32'(err), 32'd0);
        tick();
        chk("wd_err", 32'(err), 32'd1);
        chk("wd_busy", 32'(busy), 32'd0);
        chk("wd_speech_kept", 32'(speech_rec), 32'd3);
        tick();
        chk("wd_err_lo", 32'(err), 32'd0);
`else
        repeat (TIMEOUT_CYC + 100) tick();
        chk("nowd_busy", 32'(busy), 32'd1);
        chk("nowd_err", 32'(err), 32'd0);
        chk("nowd_speech_kept", 32'(speech_rec), 32'd3);
        nn_done = 1'b1; nn_value = 2'd0;
        exp_q.push_back(2'd0);
        tick();
        nn_done = 1'b0;
        chk("nowd_rec_valid", 32'(rec_valid), 32'd1);
        chk("nowd_speech", 32'(speech_rec), 32'd0);
        tick();
`endif
        tick();
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
